// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the instruction RAM it fills.
package imem_loader_pkg;

    // Default instruction memory size in 32-bit words.
    localparam int IMEM_DEPTH     = 64;

    // Incoming bytes packed into each instruction word.
    localparam int BYTES_PER_WORD = 4;

    // One-hot so that the write strobe is a single flop output.
    typedef enum logic [3:0] {
        IDLE  = 4'b0001,
        RECV  = 4'b0010,
        WRITE = 4'b0100,
        DONE  = 4'b1000
    } state_t;

    // Bit position of WRITE within the one-hot state vector.
    localparam int ST_WRITE_BIT = 2;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: packs little-endian bytes into 32-bit
// words, writes them to consecutive word addresses, and holds the core until done.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [CNT_W-1:0] num_words_i,
    input  logic             byte_valid_i,
    input  logic [7:0]       byte_data_i,
    output logic             byte_ready_o,
    output logic             mem_we_o,
    output logic [31:0]      mem_addr_o,
    output logic [31:0]      mem_wdata_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             cpu_hold_o,
    output logic [CNT_W-1:0] word_count_o
);

    localparam int               BIDX_W    = $clog2(BYTES_PER_WORD);
    localparam int               AW_PAD    = 32 - CNT_W - 2;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);
    localparam logic [BIDX_W-1:0] LAST_BYTE = BIDX_W'(BYTES_PER_WORD - 1);

    state_t              state_q;
    state_t              state_d;
    logic [CNT_W-1:0]    n_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [BIDX_W-1:0]   bidx_q;
    logic [31:0]         asm_q;

    logic                start_ok;
    logic                byte_acc;
    logic [CNT_W-1:0]    n_clamped;
    logic [CNT_W-1:0]    cnt_inc;
    logic                last_word;

    // Requested length limited to the memory size so addresses stay in range.
    assign n_clamped = (num_words_i > DEPTH_C) ? DEPTH_C : num_words_i;
    // A start is only honoured when no load is in flight.
    assign start_ok  = start_i && ((state_q == IDLE) || (state_q == DONE));
    assign byte_acc  = byte_valid_i && (state_q == RECV);
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_word = (cnt_inc == n_q);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    state_d = (n_clamped == '0) ? DONE : RECV;
                end
            end
            RECV: begin
                if (byte_valid_i && (bidx_q == LAST_BYTE)) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d = last_word ? DONE : RECV;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Load length, word counter, byte index and word assembly register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_q    <= '0;
            cnt_q  <= '0;
            bidx_q <= '0;
            asm_q  <= '0;
        end else begin
            if (start_ok) begin
                n_q    <= n_clamped;
                cnt_q  <= '0;
                bidx_q <= '0;
            end
            if (byte_acc) begin
                // Byte k lands in bits [8k+7:8k]; the index wraps to 0 after the last byte.
                asm_q[8*bidx_q +: 8] <= byte_data_i;
                bidx_q               <= bidx_q + BIDX_W'(1);
            end
            if (state_q == WRITE) begin
                cnt_q <= cnt_inc;
            end
        end
    end

    // Outputs decoded from state; the write strobe is taken directly from the WRITE flop.
    always_comb begin
        byte_ready_o = 1'b0;
        busy_o       = 1'b0;
        done_o       = 1'b0;
        cpu_hold_o   = 1'b1;
        mem_we_o     = state_q[ST_WRITE_BIT];
        mem_addr_o   = '0;
        mem_wdata_o  = '0;
        case (state_q)
            RECV: begin
                byte_ready_o = 1'b1;
                busy_o       = 1'b1;
            end
            WRITE: begin
                busy_o      = 1'b1;
                mem_addr_o  = {{AW_PAD{1'b0}}, cnt_q, 2'b00};
                mem_wdata_o = asm_q;
            end
            DONE: begin
                done_o     = 1'b1;
                cpu_hold_o = 1'b0;
            end
            default: begin
                cpu_hold_o = 1'b1;
            end
        endcase
    end

    assign word_count_o = cnt_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of loads plus hand-written restart/reset sequences,
// with an expected-write queue checked against the writes the DUT issues.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int DEPTH = 64;
    localparam int CNT_W = 7;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start_i;
    logic [CNT_W-1:0] num_words_i;
    logic             byte_valid_i;
    logic [7:0]       byte_data_i;
    logic             byte_ready_o;
    logic             mem_we_o;
    logic [31:0]      mem_addr_o;
    logic [31:0]      mem_wdata_o;
    logic             busy_o;
    logic             done_o;
    logic             cpu_hold_o;
    logic [CNT_W-1:0] word_count_o;

    always #5 clk = ~clk;

    imem_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start_i      (start_i),
        .num_words_i  (num_words_i),
        .byte_valid_i (byte_valid_i),
        .byte_data_i  (byte_data_i),
        .byte_ready_o (byte_ready_o),
        .mem_we_o     (mem_we_o),
        .mem_addr_o   (mem_addr_o),
        .mem_wdata_o  (mem_wdata_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .cpu_hold_o   (cpu_hold_o),
        .word_count_o (word_count_o)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        ready;
        int          ofs;
    } obs_t;

    typedef struct {
        int n_req;
        int n_exp;
        bit rnd;
    } vec_t;

    wr_t         expq[$];
    obs_t        obs[$];
    logic [31:0] prog [DEPTH];
    logic [31:0] mem_model [DEPTH];
    vec_t        vecs [6];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int start_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe seen mid-cycle, with its landing edge relative to start.
    always @(negedge clk) begin
        if (mem_we_o) begin
            obs.push_back('{addr: mem_addr_o, data: mem_wdata_o, ready: byte_ready_o,
                            ofs: cyc - start_cyc + 1});
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] img_word(input int i);
        logic [31:0] w;
        if (i == 0)      w = 32'h0050_0513;
        else if (i == 1) w = 32'h00B5_05B3;
        else             w = (32'(i) * 32'h9E37_79B9) ^ 32'h0000_0013;
        return w;
    endfunction

    task automatic fill_prog();
        for (int i = 0; i < DEPTH; i++) prog[i] = img_word(i);
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_ready"}, byte_ready_o, 0);
        check({tag, "_we"},    mem_we_o, 0);
        check({tag, "_addr"},  mem_addr_o, 0);
        check({tag, "_wdata"}, mem_wdata_o, 0);
        check({tag, "_busy"},  busy_o, 0);
        check({tag, "_done"},  done_o, 0);
        check({tag, "_hold"},  cpu_hold_o, 1);
        check({tag, "_count"}, word_count_o, 0);
    endtask

    task automatic do_start(input int n);
        @(negedge clk);
        start_i     = 1'b1;
        num_words_i = CNT_W'(n);
        @(posedge clk);
        #1;
        start_cyc   = cyc;
        start_i     = 1'b0;
        num_words_i = '0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int  g = 0;
        bit  fin = 0;
        while (!fin) begin
            @(negedge clk);
            byte_data_i  = b;
            byte_valid_i = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (byte_valid_i && byte_ready_o) begin
                fin = 1;
            end else if (++g > 1000) begin
                n_tests++;
                n_fail++;
                $display("FAIL byte_timeout: byte 0x%0h not accepted in %0d cycles", b, g);
                fin = 1;
            end
        end
    endtask

    task automatic send_word(input int i, input bit rnd);
        for (int b = 0; b < 4; b++) send_byte(prog[i][8*b +: 8], rnd);
    endtask

    task automatic push_exp(input int n);
        for (int i = 0; i < n; i++) expq.push_back('{addr: 32'(4 * i), data: prog[i]});
    endtask

    task automatic finish_load(input int n_exp, input bit rnd, input string tag);
        int          g = 0;
        wr_t         e;
        obs_t        o;
        logic [31:0] last_addr = '0;
        @(negedge clk);
        byte_valid_i = 1'b0;
        while (!done_o && g < 50) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_done"},  done_o, 1);
        check({tag, "_hold"},  cpu_hold_o, 0);
        check({tag, "_busy"},  busy_o, 0);
        check({tag, "_count"}, word_count_o, 64'(n_exp));
        check({tag, "_nwrites"}, 64'(obs.size()), 64'(expq.size()));
        for (int i = 0; i < n_exp && obs.size() > 0 && expq.size() > 0; i++) begin
            e = expq.pop_front();
            o = obs.pop_front();
            check($sformatf("%s_addr%0d", tag, i),  o.addr, e.addr);
            check($sformatf("%s_data%0d", tag, i),  o.data, e.data);
            check($sformatf("%s_rdy%0d", tag, i),   o.ready, 0);
            if (!rnd) check($sformatf("%s_cyc%0d", tag, i), 64'(o.ofs), 64'(5 * (i + 1)));
            if (o.addr < 32'(4 * DEPTH)) mem_model[o.addr[31:2]] = o.data;
            last_addr = o.addr;
        end
        if (n_exp > 0) check({tag, "_lastaddr"}, last_addr, 64'(4 * (n_exp - 1)));
        obs.delete();
        expq.delete();
    endtask

    task automatic run_load(input int n_req, input int n_exp, input bit rnd, input string tag);
        obs.delete();
        expq.delete();
        push_exp(n_exp);
        do_start(n_req);
        if (n_exp == 0) begin
            check({tag, "_done1"}, done_o, 1);
        end else begin
            check({tag, "_busy1"}, busy_o, 1);
        end
        for (int i = 0; i < n_exp; i++) send_word(i, rnd);
        finish_load(n_exp, rnd, tag);
    endtask

    initial begin
        int g;
        vecs[0] = '{n_req: 2,   n_exp: 2,  rnd: 1'b0};
        vecs[1] = '{n_req: 2,   n_exp: 2,  rnd: 1'b1};
        vecs[2] = '{n_req: 0,   n_exp: 0,  rnd: 1'b0};
        vecs[3] = '{n_req: 1,   n_exp: 1,  rnd: 1'b0};
        vecs[4] = '{n_req: 5,   n_exp: 5,  rnd: 1'b1};
        vecs[5] = '{n_req: 100, n_exp: 64, rnd: 1'b0};

        reset_n      = 1'b0;
        start_i      = 1'b0;
        num_words_i  = '0;
        byte_valid_i = 1'b0;
        byte_data_i  = '0;
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
        fill_prog();
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        reset_n = 1'b1;

        for (int v = 0; v < 6; v++) begin
            run_load(vecs[v].n_req, vecs[v].n_exp, vecs[v].rnd, $sformatf("vec%0d", v));
        end

        // Start pulsed while busy after the first word: must be ignored.
        obs.delete();
        expq.delete();
        for (int i = 0; i < 3; i++) prog[i] = img_word(i + 10);
        push_exp(3);
        do_start(3);
        send_word(0, 1'b0);
        @(negedge clk);
        byte_valid_i = 1'b0;
        g = 0;
        while (obs.size() < 1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        @(negedge clk);
        start_i     = 1'b1;
        num_words_i = CNT_W'(1);
        @(posedge clk);
        #1;
        start_i     = 1'b0;
        num_words_i = '0;
        check("busy_restart_busy",  busy_o, 1);
        check("busy_restart_count", word_count_o, 1);
        send_word(1, 1'b1);
        send_word(2, 1'b1);
        finish_load(3, 1'b1, "busyst");

        // Restart from DONE with a single word.
        prog[0] = 32'hDEAD_BEEF;
        run_load(1, 1, 1'b0, "restart");
        check("restart_mem0", mem_model[0], 32'hDEAD_BEEF);

        // Reset in the middle of word 1.
        fill_prog();
        obs.delete();
        do_start(2);
        send_word(0, 1'b0);
        send_byte(prog[1][7:0], 1'b0);
        send_byte(prog[1][15:8], 1'b0);
        @(negedge clk);
        byte_valid_i = 1'b0;
        // The first word's write already happened; discard it and watch for any further write.
        obs.delete();
        reset_n = 1'b0;
        #1;
        check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        check("midrst_nowrite", 64'(obs.size()), 0);
        reset_n = 1'b1;
        run_load(2, 2, 1'b0, "postrst");

        // Full image, then read back through the memory model at A = 4i.
        for (int i = 0; i < DEPTH; i++) mem_model[i] = '0;
        run_load(64, 64, 1'b1, "full");
        for (int i = 0; i < DEPTH; i++) begin
            check($sformatf("imem_rd_%0d", i), mem_model[(4 * i) >> 2], prog[i]);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
